// File: rtl/mdio_frame_master.sv
// Clause 22 MDIO master: turns one register read/write request into a full
// MDC/MDIO frame (preamble, ST, OP, PHYAD, REGAD, TA, DATA, idle bit).
module mdio_frame_master #(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  output logic        RDY,
  input  logic        OP_WR,
  input  logic [4:0]  PHY_ADR,
  input  logic [4:0]  REG_ADR,
  input  logic [15:0] WR_DATA,
  output logic [15:0] RD_DATA,
  output logic        DONE,
  output logic        ERR,
  output logic        E_MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_Z,
  input  logic        MDIO_IN
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_ST,
    S_OP,
    S_PHY,
    S_REG,
    S_TA,
    S_DATA,
    S_IDLEBIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mdc_q, mdc_d;
  logic               mdo_q, mdo_d;
  logic               mdz_q, mdz_d;
  logic               rdy_q, rdy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        rd_q, rd_d;
  logic [15:0]        sh_q, sh_d;
  logic               ta_err_q, ta_err_d;
  logic               wr_q, wr_d;
  logic [4:0]         pa_q, pa_d;
  logic [4:0]         ra_q, ra_d;
  logic [15:0]        wd_q, wd_d;
  logic [1:0]         sync_q;
  logic               load;

  // Pin values {z, out} for bit cnt (MSB-first) of field s.
  function automatic logic [1:0] drive_bit(input state_t s, input logic [CNT_W-1:0] c,
                                           input logic wr, input logic [4:0] pa,
                                           input logic [4:0] ra, input logic [15:0] wd);
    logic [1:0] v;
    v = 2'b11;
    case (s)
      S_PRE:  v = 2'b01;
      S_ST:   v = {1'b0, ~c[0]};
      S_OP:   v = {1'b0, wr ? ~c[0] : c[0]};
      S_PHY:  v = {1'b0, pa[c[2:0]]};
      S_REG:  v = {1'b0, ra[c[2:0]]};
      S_TA:   v = wr ? {1'b0, c[0]} : 2'b11;
      S_DATA: v = wr ? {1'b0, wd[c[3:0]]} : 2'b11;
      default: v = 2'b11;
    endcase
    return v;
  endfunction

  // Next-state: MDC divider, field sequencing, sampling and completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    mdc_d    = mdc_q;
    mdo_d    = mdo_q;
    mdz_d    = mdz_q;
    rdy_d    = rdy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rd_d     = rd_q;
    sh_d     = sh_q;
    ta_err_d = ta_err_q;
    wr_d     = wr_q;
    pa_d     = pa_q;
    ra_d     = ra_q;
    wd_d     = wd_q;
    load     = 1'b0;

    if (state_q == S_IDLE) begin
      if (REQ) begin
        wr_d  = OP_WR;
        pa_d  = PHY_ADR;
        ra_d  = REG_ADR;
        wd_d  = WR_DATA;
        rdy_d = 1'b0;
        div_d = '0;
        mdc_d = 1'b0;
        load  = 1'b1;
        if (PRE_LEN != 0) begin
          state_d = S_PRE;
          cnt_d   = CNT_W'(PRE_LEN - 1);
        end else begin
          state_d = S_ST;
          cnt_d   = CNT_W'(1);
        end
      end
    end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d = '0;
      if (!mdc_q) begin
        // Rising MDC: sample the synchronised input.
        mdc_d = 1'b1;
        if (state_q == S_TA && cnt_q == '0) ta_err_d = sync_q[1];
        if (state_q == S_DATA) sh_d = {sh_q[14:0], sync_q[1]};
      end else begin
        mdc_d = 1'b0;
        load  = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          case (state_q)
            S_PRE:  begin state_d = S_ST;      cnt_d = CNT_W'(1);  end
            S_ST:   begin state_d = S_OP;      cnt_d = CNT_W'(1);  end
            S_OP:   begin state_d = S_PHY;     cnt_d = CNT_W'(4);  end
            S_PHY:  begin state_d = S_REG;     cnt_d = CNT_W'(4);  end
            S_REG:  begin state_d = S_TA;      cnt_d = CNT_W'(1);  end
            S_TA:   begin state_d = S_DATA;    cnt_d = CNT_W'(15); end
            S_DATA: begin state_d = S_IDLEBIT; cnt_d = CNT_W'(0);  end
            default: begin
              state_d = S_IDLE;
              cnt_d   = '0;
              rdy_d   = 1'b1;
              done_d  = 1'b1;
              err_d   = ~wr_q & ta_err_q;
              if (!wr_q) rd_d = sh_q;
              load    = 1'b0;
              mdz_d   = 1'b1;
              mdo_d   = 1'b1;
            end
          endcase
        end
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (load) {mdz_d, mdo_d} = drive_bit(state_d, cnt_d, wr_d, pa_d, ra_d, wd_d);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      mdc_q    <= 1'b0;
      mdo_q    <= 1'b1;
      mdz_q    <= 1'b1;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
      sh_q     <= '0;
      ta_err_q <= 1'b0;
      wr_q     <= 1'b0;
      pa_q     <= '0;
      ra_q     <= '0;
      wd_q     <= '0;
      sync_q   <= 2'b11;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      mdc_q    <= mdc_d;
      mdo_q    <= mdo_d;
      mdz_q    <= mdz_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      sh_q     <= sh_d;
      ta_err_q <= ta_err_d;
      wr_q     <= wr_d;
      pa_q     <= pa_d;
      ra_q     <= ra_d;
      wd_q     <= wd_d;
      sync_q   <= {sync_q[0], MDIO_IN};
    end
  end

  assign RDY      = rdy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RD_DATA  = rd_q;
  assign E_MDC    = mdc_q;
  assign MDIO_OUT = mdo_q;
  assign MDIO_Z   = mdz_q;

endmodule

// File: tb/tb_mdio_frame_master.sv
// Scoreboard bench for mdio_frame_master: two parameter sets, each with a PHY
// model that decodes the serial header and answers reads for address 3.
module tb_mdio_frame_master;

  localparam int unsigned VW = 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic            wr;
    logic [15:0]     rd;
    logic            err;
    logic [VW-1:0]   out_v;
    logic [VW-1:0]   z_v;
    int              nbits;
    int              acc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic        hold;
    int          abort_at;
  } req_t;

  // PHY register contents at address 3.
  function automatic logic [15:0] phy_reg(input logic [4:0] ra);
    return (ra == 5'd2) ? 16'h796D : (16'h3C00 ^ {11'h0, ra});
  endfunction

  function automatic exp_t build(input int pl, input logic wr, input logic [4:0] pa,
                                 input logic [4:0] ra, input logic [15:0] wd, input int acc);
    exp_t e;
    logic [31:0] f;
    f = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra, (wr ? 2'b10 : 2'b00), (wr ? wd : 16'h0)};
    e.out_v = '0;
    e.z_v   = '0;
    for (int k = 0; k < pl; k++) e.out_v[k] = 1'b1;
    for (int k = 0; k < 32; k++) begin
      e.out_v[pl+k] = f[31-k];
      e.z_v[pl+k]   = !wr && (k >= 14);
    end
    e.z_v[pl+32] = 1'b1;
    e.nbits = pl + 33;
    e.wr    = wr;
    e.acc   = acc;
    e.err   = !wr && (pa != 5'd3);
    e.rd    = (pa == 5'd3) ? phy_reg(ra) : 16'hFFFF;
    return e;
  endfunction

  function automatic req_t tbl(input int g, input int k);
    req_t r;
    r = '{wr: 1'b0, pa: 5'd3, ra: 5'd2, wd: 16'h0, hold: 1'b0, abort_at: -1};
    if (g == 0) begin
      case (k)
        0: r = '{1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, -1};
        1: r = '{1'b0, 5'd3, 5'd2, 16'h0000, 1'b0, -1};
        2: r = '{1'b0, 5'd7, 5'd2, 16'h0000, 1'b0, -1};
        3: r = '{1'b1, 5'd3, 5'd4, 16'hBEEF, 1'b0, 40};
        default: r = '{1'b0, 5'd3, 5'd2, 16'h0000, 1'b0, -1};
      endcase
    end else begin
      case (k)
        0: r = '{1'b1, 5'd3, 5'd0, 16'h8001, 1'b1, -1};
        1: r = '{1'b0, 5'd3, 5'd2, 16'h0000, 1'b1, -1};
        2: r = '{1'b1, 5'd5, 5'd31, 16'hA5A5, 1'b0, -1};
        default: r = '{1'b0, 5'd3, 5'd9, 16'h0000, 1'b0, -1};
      endcase
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_cfg
    localparam int unsigned CD  = (g == 0) ? 4 : 2;
    localparam int unsigned PL  = (g == 0) ? 32 : 0;
    localparam int          LAT = int'((PL + 33) * 2 * CD);
    localparam int          NE  = (g == 0) ? 5 : 4;

    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        op_wr = 1'b0;
    logic [4:0]  phy_adr = '0;
    logic [4:0]  reg_adr = '0;
    logic [15:0] wr_data = '0;
    logic        rdy, done, err, e_mdc, mdio_out, mdio_z;
    logic [15:0] rd_data;
    logic        mdio_in = 1'b1;

    mdio_frame_master #(.CLK_DIV(CD), .PRE_LEN(PL)) u_dut (
      .CLK(clk), .RST(rst), .REQ(req), .RDY(rdy), .OP_WR(op_wr),
      .PHY_ADR(phy_adr), .REG_ADR(reg_adr), .WR_DATA(wr_data),
      .RD_DATA(rd_data), .DONE(done), .ERR(err), .E_MDC(e_mdc),
      .MDIO_OUT(mdio_out), .MDIO_Z(mdio_z), .MDIO_IN(mdio_in)
    );

    exp_t        sbq[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          last_acc_cyc = 0;
    int          last_done_cyc = 0;
    logic [15:0] last_rd = 16'h0;
    bit          frame_start = 1'b0;
    bit          fin = 1'b0;

    // Acceptance: push the expected frame when REQ meets RDY.
    always @(posedge clk) begin
      cyc++;
      if (!rst && req && rdy) begin
        sbq.push_back(build(int'(PL), op_wr, phy_adr, reg_adr, wr_data, cyc));
        acc_cnt++;
        last_acc_cyc = cyc;
        frame_start = 1'b1;
      end
    end

    int            r = 0;
    int            run = 0;
    logic [13:0]   hdr = '0;
    logic          resp = 1'b0;
    logic [15:0]   rdat = '0;
    logic [VW-1:0] ov = '0;
    logic [VW-1:0] zv = '0;
    logic          mdc_p = 1'b0;
    logic          done_p = 1'b0;

    // Serial monitor, PHY model and DONE scoreboard.
    always @(negedge clk) begin
      exp_t e;
      int   i;
      if (frame_start) begin
        frame_start = 1'b0;
        r = 0; run = 1; ov = '0; zv = '0; hdr = '0; resp = 1'b0; mdio_in = 1'b1;
      end else if (rst) begin
        run = 0;
      end else if (e_mdc != mdc_p) begin
        if (run != 0) check("mdc_half", VW'(run), VW'(CD));
        run = 1;
        if (e_mdc && r < int'(VW)) begin
          ov[r] = mdio_out;
          zv[r] = mdio_z;
          i = r - int'(PL);
          if (i >= 0 && i <= 13) hdr = {hdr[12:0], mdio_out};
          if (i == 13) begin
            resp = (hdr[11:10] == 2'b10) && (hdr[9:5] == 5'd3);
            rdat = phy_reg(hdr[4:0]);
          end
          if (resp && i == 14) mdio_in = 1'b0;
          else if (resp && i >= 15 && i <= 30) mdio_in = rdat[30-i];
          else if (i == 31) mdio_in = 1'b1;
          r++;
        end
      end else if (run != 0) begin
        run++;
      end

      if (!rst) begin
        if (done_p) check("done_pulse", VW'(done), VW'(0));
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
          if (sbq.size() == 0) begin
            check("unexpected_done", VW'(1), VW'(0));
          end else begin
            e = sbq.pop_front();
            if (e.wr) e.rd = last_rd;
            last_rd = e.rd;
            check("latency", VW'(cyc - e.acc), VW'(LAT));
            check("rd_data", VW'(rd_data), VW'(e.rd));
            check("err", VW'(err), VW'(e.err));
            check("done_pins", VW'({rdy, e_mdc, mdio_z}), VW'(3'b101));
            check("nbits", VW'(r), VW'(e.nbits));
            check("stream", ov & ~e.z_v, e.out_v & ~e.z_v);
            check("tristate", zv, e.z_v);
          end
        end
      end
      mdc_p  = e_mdc;
      done_p = rst ? 1'b0 : done;
    end

    // Stimulus: table of requests, with busy-time REQ pulses and one abort.
    initial begin
      req_t q;
      int   t;
      int   start;
      int   want_done;
      bit   prev_hold;
      want_done = 0;
      prev_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", VW'({rdy, e_mdc, mdio_z, mdio_out, done, err, rd_data}),
            VW'({6'b101100, 16'h0000}));
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      for (int k = 0; k < NE; k++) begin
        q = tbl(g, k);
        start = acc_cnt;
        op_wr = q.wr; phy_adr = q.pa; reg_adr = q.ra; wr_data = q.wd; req = 1'b1;
        t = 0;
        while (acc_cnt == start && t < 2 * LAT + 20) begin @(posedge clk); #1; t++; end
        check("accept_timeout", VW'(acc_cnt == start), VW'(0));
        if (prev_hold) check("b2b_accept", VW'(last_acc_cyc), VW'(last_done_cyc + 1));
        prev_hold = q.hold;
        if (q.abort_at < 0) want_done++;
        if (q.hold) continue;

        req = 1'b0;
        repeat (LAT / 3) begin @(posedge clk); #1; end
        op_wr = 1'($urandom); phy_adr = 5'($urandom); reg_adr = 5'($urandom);
        wr_data = 16'($urandom); req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;

        if (q.abort_at >= 0) begin
          t = 0;
          while (r < q.abort_at && t < 2 * LAT) begin @(posedge clk); #1; t++; end
          check("abort_timeout", VW'(r < q.abort_at), VW'(0));
          rst = 1'b1;
          @(posedge clk);
          @(negedge clk);
          check("abort_state", VW'({rdy, e_mdc, mdio_z, mdio_out, done, rd_data}),
                VW'({5'b10110, 16'h0000}));
          @(posedge clk); #1;
          rst = 1'b0;
          sbq.delete();
          last_rd = 16'h0;
          repeat (20) begin @(posedge clk); #1; end
        end else begin
          t = 0;
          while (done_cnt < want_done && t < 3 * LAT) begin @(posedge clk); #1; t++; end
          check("done_timeout", VW'(done_cnt < want_done), VW'(0));
        end
      end
      repeat (10) begin @(posedge clk); #1; end
      check("sb_empty", VW'(sbq.size()), VW'(0));
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(gen_cfg[0].fin && gen_cfg[1].fin) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    check("global_timeout", VW'(t >= 50000), VW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_frame_master.md
Name: mdio_frame_master

Overview:
- Hardware IEEE 802.3 Clause 22 MDIO master. Serialises one PHY register read or write per request into a complete MDC/MDIO frame.
- Replaces bit-banged MDIO from a soft processor. Register-access clients (link-speed poller, debug port) issue single-word requests and receive 16-bit read data plus a no-PHY error flag.
- Drives the E_MDC pin and the MDIO bidirectional buffer (data and tristate enable) directly.

Parameters:
CLK_DIV, 10, CLK cycles per MDC half-period (MDC = CLK/(2*CLK_DIV)); legal range 2..255
PRE_LEN, 32, preamble bits (all ones) sent before each frame; legal range 0..32

Ports:
CLK  in  1  master clock
RST  in  1  synchronous active-high reset
REQ  in  1  request strobe; accepted only when RDY=1
RDY  out  1  1 = idle and able to accept REQ
OP_WR  in  1  1 = write frame, 0 = read frame; captured with REQ
PHY_ADR  in  5  PHY address; captured with REQ
REG_ADR  in  5  register address; captured with REQ
WR_DATA  in  16  write data; captured with REQ
RD_DATA  out  16  last read result; held until next read completes
DONE  out  1  one-cycle pulse at frame completion (read or write)
ERR  out  1  valid with DONE: 1 = read turnaround bit sampled high (no PHY); 0 for writes
E_MDC  out  1  MDIO clock to PHY
MDIO_OUT  out  1  MDIO output data to IOBUF I
MDIO_Z  out  1  IOBUF T: 1 = high-Z, 0 = drive
MDIO_IN  in  1  MDIO input from IOBUF O

Behaviour:
- Reset (sync, RST=1 at a CLK edge), all outputs registered:
  - RDY=1, E_MDC=0, MDIO_Z=1, MDIO_OUT=1, DONE=0, ERR=0, RD_DATA=0.
  - State IDLE, counters cleared.
  - Reset mid-frame aborts immediately. No DONE pulse is generated for the aborted frame.
- Acceptance:
  - On the cycle REQ=1 and RDY=1, capture OP_WR, PHY_ADR, REG_ADR and WR_DATA. RDY goes 0 next cycle.
  - REQ while RDY=0 is ignored; it is not queued.
- Bit timing:
  - Each bit lasts 2*CLK_DIV cycles: MDC low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MDIO_OUT and MDIO_Z update only on the cycle MDC goes low (start of bit).
  - MDIO_IN is sampled on the cycle MDC goes high.
  - First bit starts the cycle after acceptance.
- Frame format (MSB first), states PRE -> ST -> OP -> PHYAD -> REGAD -> TA -> DATA -> IDLEBIT -> IDLE:
  - PRE: PRE_LEN ones. Skipped when PRE_LEN=0.
  - ST: 0,1.
  - OP: write 0,1; read 1,0.
  - PHYAD: 5 bits. REGAD: 5 bits.
  - TA, write: drive 1,0.
  - TA, read: MDIO_Z=1 from the first TA bit onward. The second TA bit is sampled; 1 sets the error flag.
  - DATA, write: drive WR_DATA[15:0].
  - DATA, read: keep MDIO_Z=1 and shift 16 samples into the shift register, MSB first.
  - IDLEBIT: one bit time with MDIO_Z=1, MDC still toggling.
- Completion:
  - At the end of IDLEBIT: DONE=1 for one cycle, ERR driven, RDY=1 the same cycle, E_MDC=0.
  - For a read, RD_DATA is updated on the DONE cycle. A read with ERR=1 still updates RD_DATA with the sampled value (0xFFFF with pull-up).
  - Writes leave RD_DATA unchanged and drive ERR=0.
- Total latency: from acceptance edge to DONE = (PRE_LEN+33)*2*CLK_DIV cycles. Default parameters give 1300 cycles.
- Back-to-back: REQ held high is accepted on the DONE cycle, because RDY=1 there. The next frame's first bit starts the following cycle.
- Bit counter width is 6 bits; a counter wrap between fields is an implementation error.
- MDIO_IN is treated as asynchronous. Pass it through a 2-flop synchroniser before sampling; this is legal because CLK_DIV>=2 gives a margin of at least 2 cycles.

Test Plan:
- Write, CLK_DIV=4, PRE_LEN=32, PHY_ADR=1, REG_ADR=0, WR_DATA=0x1140 -> serial stream on MDC rising edges is 32x1, 01, 01, 00001, 00000, 10, 0001000101000000. MDIO_Z=0 throughout the frame and 1 in IDLEBIT. DONE at acceptance+520 cycles, ERR=0.
- Read, PHY model at address 3 returns 0x796D for REG_ADR=2 -> MDIO_Z=1 from the first TA bit. RD_DATA=0x796D and ERR=0 on the DONE cycle; RDY=1 the same cycle.
- Read with no PHY (MDIO_IN held 1 by pull-up) -> DONE with ERR=1, RD_DATA=0xFFFF.
- RST asserted at bit 40 of a write -> next cycle E_MDC=0, MDIO_Z=1, RDY=1, with no DONE pulse. A new read issued afterwards completes normally.
- REQ held high for 3 frames (write, read, write), PRE_LEN=0 -> three DONE pulses exactly 33*2*CLK_DIV cycles apart, and REQ pulses during busy are ignored.
- CLK_DIV=2 boundary -> MDC period is 4 CLK cycles, duty cycle 50%, and read data is still captured correctly through the synchroniser.
